// File: rtl/add_arbiter.sv
// add_arbiter
// Round-robin scheduler that shares one combinational 32-bit adder between
// N_REQ requesters. Each cycle at most one eligible requester is granted; its
// operands are steered onto the adder and the sum/carry-out is captured into
// that requester's response register, held until the requester consumes it.
//
// Optional feature: define ADD_ARB_SUB_EN to enable subtraction (req_sub = 1
// computes A - B by inverting B and forcing carry-in). Without the macro
// req_sub is ignored and every operation is a plain add.
module add_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic                 add_clk,
    input  logic                 add_rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_sub,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [32*N_REQ-1:0]  rsp_sum,
    output logic [N_REQ-1:0]     rsp_cout,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_cin,
    input  logic [31:0]          add_s,
    input  logic [31:0]          add_cout,
    output logic                 busy
);

    logic [PTR_W-1:0] ptr_r;
    logic [N_REQ-1:0] eligible_s;
    logic             grant_found_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic             grant_any_s;
    logic [N_REQ-1:0] grant_vec_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic             sub_sel_s;
    logic [31:0]      sel_a_s;
    logic [31:0]      sel_b_s;
    logic             unused_cout_s;

    // Only the carry out of bit 31 matters; the rest of the chain is ignored.
    assign unused_cout_s = ^add_cout[30:0];

`ifndef ADD_ARB_SUB_EN
    logic             unused_sub_s;
    assign unused_sub_s = ^req_sub;
`endif

    // A requester still holding an unconsumed result may not issue again.
    assign eligible_s = req_valid & ~rsp_valid;

    // Pick the eligible requester closest to ptr in rotation order.
    always_comb begin
        int   rank_s;
        int   best_rank_s;
        logic take_s;
        rank_s        = 0;
        best_rank_s   = N_REQ;
        take_s        = 1'b0;
        grant_found_s = 1'b0;
        grant_idx_s   = {PTR_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            rank_s        = (i >= int'(ptr_r)) ? (i - int'(ptr_r))
                                               : (i - int'(ptr_r) + N_REQ);
            take_s        = eligible_s[i] & (rank_s < best_rank_s);
            best_rank_s   = take_s ? rank_s : best_rank_s;
            grant_idx_s   = take_s ? PTR_W'(i) : grant_idx_s;
            grant_found_s = grant_found_s | take_s;
        end
    end

    // Reset forces the grant off so nothing leaks onto the adder mid-reset.
    assign grant_any_s = grant_found_s & add_rst_n;

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        grant_vec_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            grant_vec_s[i] = grant_any_s & (grant_idx_s == PTR_W'(i));
        end
    end

    assign req_ready  = grant_vec_s;
    assign next_ptr_s = (grant_idx_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}}
                                                          : grant_idx_s + PTR_W'(1'b1);
    assign busy       = add_rst_n & ((|rsp_valid) | grant_any_s);

    // Steer the granted requester's operands onto the shared adder (AND-OR mux).
    always_comb begin
        sel_a_s   = 32'd0;
        sel_b_s   = 32'd0;
        sub_sel_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = sel_a_s | ({32{grant_vec_s[i]}} & req_a[32*i +: 32]);
            sel_b_s = sel_b_s | ({32{grant_vec_s[i]}} & req_b[32*i +: 32]);
        end
`ifdef ADD_ARB_SUB_EN
        sub_sel_s = |(grant_vec_s & req_sub);
`endif
        add_a   = sel_a_s;
        add_b   = sub_sel_s ? ~sel_b_s : sel_b_s;
        add_cin = sub_sel_s;
    end

    // Capture results for the granted requester, clear on consume, rotate ptr.
    always_ff @(posedge add_clk or negedge add_rst_n) begin
        if (!add_rst_n) begin
            ptr_r     <= {PTR_W{1'b0}};
            rsp_valid <= {N_REQ{1'b0}};
            rsp_sum   <= {(32*N_REQ){1'b0}};
            rsp_cout  <= {N_REQ{1'b0}};
        end else begin
            if (grant_any_s) begin
                ptr_r <= next_ptr_s;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_vec_s[i]) begin
                    rsp_sum[32*i +: 32] <= add_s;
                    rsp_cout[i]         <= add_cout[31];
                    rsp_valid[i]        <= 1'b1;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i]        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus a randomized run,
// all compared against a transaction-level reference model (rotation order,
// held results, plain modulo-2^32 arithmetic). The bench also plays the role of
// the shared adder and puts noise on the unused carry-chain bits.
module tb_add_arbiter;
    localparam int N = 4;

    logic            add_clk = 1'b0;
    logic            add_rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, req_sub = '0;
    logic [N-1:0]    rsp_valid, rsp_ready = '0, rsp_cout;
    logic [32*N-1:0] req_a, req_b, rsp_sum;
    logic [31:0]     add_a, add_b, add_s, add_cout;
    logic            add_cin, busy;
    logic [31:0]     a_v[N], b_v[N], sum_v[N];
    logic [30:0]     noise = '0;
    logic [32:0]     wide;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_ptr = 0;
    logic        m_rv[N];
    logic [31:0] m_sum[N];
    logic        m_cout[N];

    always #5 add_clk = ~add_clk;

    add_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
        .add_clk(add_clk), .add_rst_n(add_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout), .busy(busy)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = a_v[i];
            req_b[32*i +: 32] = b_v[i];
            sum_v[i]          = rsp_sum[32*i +: 32];
        end
    end

    // the shared adder; low carry bits carry noise since only bit 31 is defined
    always_comb begin
        wide     = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        add_s    = wide[31:0];
        add_cout = {wide[32], noise};
    end

    always @(negedge add_clk) noise <= 31'($urandom);

    function automatic int exp_grant();
        int i;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && !m_rv[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = exp_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_sub(int g);
`ifdef ADD_ARB_SUB_EN
        return req_sub[g];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [N-1:0] pack_rv();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_rv[i];
        return r;
    endfunction

    function automatic logic [N-1:0] pack_cout();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_cout[i];
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_rv[i] = 1'b0; m_sum[i] = 32'd0; m_cout[i] = 1'b0;
        end
    endtask

    // one clock edge for both DUT and model; ends 1 time unit after the edge
    task automatic tick();
        int g;
        logic [32:0] t;
        g = exp_grant();
        @(posedge add_clk);
        for (int i = 0; i < N; i++) begin
            if (i == g) begin
                m_rv[i] = 1'b1;
                if (exp_sub(g)) begin
                    m_sum[i]  = a_v[i] - b_v[i];
                    m_cout[i] = (a_v[i] >= b_v[i]);
                end else begin
                    t = {1'b0, a_v[i]} + {1'b0, b_v[i]};
                    m_sum[i]  = t[31:0];
                    m_cout[i] = t[32];
                end
            end else if (rsp_ready[i]) begin
                m_rv[i] = 1'b0;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % N;
        #1;
    endtask

    task automatic drain();
        req_valid = '0; req_sub = '0; rsp_ready = '1;
        tick(); tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        add_rst_n = 1'b0;
        req_valid = '1; rsp_ready = '0;
        for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
        #2;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_vec++; if ({add_a, add_b, add_cin} !== 65'd0) begin n_err++; $display("FAIL reset_adder: got %h %h %b want zeros", add_a, add_b, add_cin); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({rsp_valid, rsp_cout} !== 8'd0) begin n_err++; $display("FAIL reset_rsp: got %b %b want zeros", rsp_valid, rsp_cout); end
        n_vec++; if (rsp_sum !== 128'd0) begin n_err++; $display("FAIL reset_sum: got %h want 0", rsp_sum); end
        req_valid = '0;
        @(negedge add_clk);
        add_rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_single_add();
        a_v[0] = 32'h0000_0005; b_v[0] = 32'h0000_0007;
        req_sub = '0; rsp_ready = '0; req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_vec++; if (add_a !== 32'd5 || add_b !== 32'd7 || add_cin !== 1'b0) begin n_err++; $display("FAIL single_operands: got %h %h %b want 5 7 0", add_a, add_b, add_cin); end
        tick();
        req_valid = '0;
        #1;
        n_vec++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_valid: got %b want 0001", rsp_valid); end
        n_vec++; if (sum_v[0] !== 32'h0000_000C || rsp_cout[0] !== 1'b0) begin n_err++; $display("FAIL single_sum: got %h/%b want 0000000c/0", sum_v[0], rsp_cout[0]); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_held: got %b want 1", busy); end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        n_vec++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL single_consume: got %b/%b want 0000/0", rsp_valid, busy); end
        n_vec++; if (sum_v[0] !== 32'h0000_000C) begin n_err++; $display("FAIL single_sum_kept: got %h want 0000000c", sum_v[0]); end
    endtask

    task automatic test_round_robin();
        int start, g;
        logic [31:0] want;
        drain();
        start = m_ptr;
        req_valid = '1; rsp_ready = '1; req_sub = '0;
        for (int k = 0; k < 2 * N; k++) begin
            for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
            g = (start + k) % N;
            want = a_v[g] + b_v[g];
            #1;
            n_vec++; if (req_ready !== (4'b0001 << g)) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, 4'b0001 << g); end
            tick();
            n_vec++; if (rsp_valid[g] !== 1'b1 || sum_v[g] !== want) begin n_err++; $display("FAIL rr_result_%0d: got %b/%h want 1/%h", k, rsp_valid[g], sum_v[g], want); end
        end
        drain();
    endtask

    task automatic test_carry();
        a_v[3] = 32'hFFFF_FFFF; b_v[3] = 32'h0000_0001;
        req_valid = 4'b1000; req_sub = '0;
        #1;
        n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL carry_ready: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        n_vec++; if (sum_v[3] !== 32'd0 || rsp_cout[3] !== 1'b1) begin n_err++; $display("FAIL carry_sum: got %h/%b want 00000000/1", sum_v[3], rsp_cout[3]); end
        drain();
    endtask

    task automatic test_sub();
        a_v[1] = 32'd3; b_v[1] = 32'd5; req_sub = 4'b0010; req_valid = 4'b0010;
        #1;
`ifdef ADD_ARB_SUB_EN
        n_vec++; if (add_b !== 32'hFFFF_FFFA || add_cin !== 1'b1) begin n_err++; $display("FAIL sub_operands: got %h/%b want fffffffa/1", add_b, add_cin); end
        tick();
        n_vec++; if (sum_v[1] !== 32'hFFFF_FFFE || rsp_cout[1] !== 1'b0) begin n_err++; $display("FAIL sub_borrow: got %h/%b want fffffffe/0", sum_v[1], rsp_cout[1]); end
`else
        n_vec++; if (add_b !== 32'd5 || add_cin !== 1'b0) begin n_err++; $display("FAIL sub_operands: got %h/%b want 00000005/0", add_b, add_cin); end
        tick();
        n_vec++; if (sum_v[1] !== 32'd8 || rsp_cout[1] !== 1'b0) begin n_err++; $display("FAIL sub_ignored: got %h/%b want 00000008/0", sum_v[1], rsp_cout[1]); end
`endif
        drain();
        a_v[1] = 32'd9; b_v[1] = 32'd4; req_sub = 4'b0010; req_valid = 4'b0010;
        tick();
`ifdef ADD_ARB_SUB_EN
        n_vec++; if (sum_v[1] !== 32'd5 || rsp_cout[1] !== 1'b1) begin n_err++; $display("FAIL sub_noborrow: got %h/%b want 00000005/1", sum_v[1], rsp_cout[1]); end
`else
        n_vec++; if (sum_v[1] !== 32'd13 || rsp_cout[1] !== 1'b0) begin n_err++; $display("FAIL sub_noborrow: got %h/%b want 0000000d/0", sum_v[1], rsp_cout[1]); end
`endif
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        a_v[1] = $urandom; b_v[1] = $urandom; req_sub = '0;
        held = a_v[1] + b_v[1];
        rsp_ready = 4'b1101; req_valid = 4'b0010;
        tick();
        n_vec++; if (rsp_valid[1] !== 1'b1 || sum_v[1] !== held) begin n_err++; $display("FAIL bp_first: got %b/%h want 1/%h", rsp_valid[1], sum_v[1], held); end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
            #1;
            n_vec++; if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_blocked_%0d: got %b want 0", k, req_ready[1]); end
            n_vec++; if (req_ready !== exp_ready() || req_ready === 4'b0000) begin n_err++; $display("FAIL bp_others_%0d: got %b want %b", k, req_ready, exp_ready()); end
            tick();
            n_vec++; if (rsp_valid[1] !== 1'b1 || sum_v[1] !== held) begin n_err++; $display("FAIL bp_stable_%0d: got %b/%h want 1/%h", k, rsp_valid[1], sum_v[1], held); end
        end
        drain();
    endtask

    task automatic test_random();
        int g;
        logic [31:0] ea, eb;
        logic ecin, ebusy;
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom); rsp_ready = N'($urandom); req_sub = N'($urandom);
            for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
            if (c % 37 == 5) begin a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF; end
            g = exp_grant();
            ea = 32'd0; eb = 32'd0; ecin = 1'b0;
            if (g >= 0) begin
                ea = a_v[g];
                eb = exp_sub(g) ? ~b_v[g] : b_v[g];
                ecin = exp_sub(g);
            end
            ebusy = (|pack_rv()) | (g >= 0);
            #1;
            n_vec++; if (req_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready_%0d: got %b want %b", c, req_ready, exp_ready()); end
            n_vec++; if (add_a !== ea || add_b !== eb || add_cin !== ecin) begin n_err++; $display("FAIL rnd_adder_%0d: got %h %h %b want %h %h %b", c, add_a, add_b, add_cin, ea, eb, ecin); end
            n_vec++; if (busy !== ebusy) begin n_err++; $display("FAIL rnd_busy_%0d: got %b want %b", c, busy, ebusy); end
            tick();
            n_vec++; if (rsp_valid !== pack_rv() || rsp_cout !== pack_cout()) begin n_err++; $display("FAIL rnd_rsp_%0d: got %b/%b want %b/%b", c, rsp_valid, rsp_cout, pack_rv(), pack_cout()); end
            for (int i = 0; i < N; i++) begin
                n_vec++; if (sum_v[i] !== m_sum[i]) begin n_err++; $display("FAIL rnd_sum_%0d_%0d: got %h want %h", c, i, sum_v[i], m_sum[i]); end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = '1; req_sub = '0;
        a_v[1] = $urandom; b_v[1] = $urandom;
        req_valid = 4'b0010;
        tick();
        rsp_ready = '0; req_valid = 4'b0100; a_v[2] = 32'd100; b_v[2] = 32'd23;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_pre_grant: got %b want 0100", req_ready); end
        #1;
        add_rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async: got %b %b %b want 0000 0000 0", rsp_valid, req_ready, busy); end
        n_vec++; if ({add_a, add_b, add_cin} !== 65'd0 || rsp_sum !== 128'd0) begin n_err++; $display("FAIL mid_clear: got %h %h %h want zeros", add_a, add_b, rsp_sum); end
        req_valid = '0;
        @(negedge add_clk);
        add_rst_n = 1'b1;
        tick();
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready); end
        req_valid = 4'b0100;
        #1;
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_req2: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        n_vec++; if (rsp_valid !== 4'b0100 || sum_v[2] !== 32'd123) begin n_err++; $display("FAIL mid_result: got %b/%h want 0100/0000007b", rsp_valid, sum_v[2]); end
        drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin a_v[i] = 32'd0; b_v[i] = 32'd0; end
        model_reset();
        test_reset();
        test_single_add();
        test_round_robin();
        test_carry();
        test_sub();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
